// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared types and constants for the mm:ss countdown timer.
//   BCDnumber_t    - one BCD digit (4'hF is reserved as the blank code)
//   timer_state_t  - run/pause/done state machine encoding
//   clamp_digit()  - saturates a loaded digit to its legal maximum
package timer_ctrl_pkg;

    typedef logic [3:0] BCDnumber_t;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} timer_state_t;

    localparam BCDnumber_t BCD_BLANK    = 4'hF;
    localparam BCDnumber_t SEC_TENS_MAX = 4'd5;
    localparam BCDnumber_t DIGIT_MAX    = 4'd9;

    function automatic BCDnumber_t clamp_digit(input BCDnumber_t d, input BCDnumber_t max);
        return (d > max) ? max : d;
    endfunction

endpackage

// File: rtl/timer_ctrl_tick_gen.sv
// tick_gen: enabled modulo-DIV prescaler producing a one-cycle pulse.
//   clk   - system clock
//   rst   - synchronous active-high clear of the count
//   en    - count enable; the count holds while low
//   pulse - high for the enabled cycle in which the count wraps (DIV-1 -> 0)
module tick_gen
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic pulse
);

    localparam logic [31:0] LAST = 32'(DIV - 1);

    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 32'd1;
        end
    end

    // Combinational so the consumer acts on the same edge that wraps the count.
    assign pulse = en && (cnt_q == LAST);

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: control block of the 4-digit mm:ss countdown timer.
// Owns the BCD count, the IDLE/RUN/PAUSE/DONE machine, the 1 s time base and
// the display scan tick.
//   clk, rst         - clock, synchronous active-high reset
//   start_stop       - pulse: IDLE->RUN (count != 0), RUN<->PAUSE
//   clear            - pulse: back to IDLE with count 00:00
//   load             - pulse: copy clamped preset into count (not in RUN)
//   preset           - load value, [0]=s units .. [3]=min tens
//   num              - current count to the digit selector
//   scan_tick        - one-cycle pulse every SCAN_DIV cycles
//   state, done      - current state, high while in DONE
// Optional: define TIMER_CTRL_BLINK_EN to blank num on alternate half-seconds
// while in PAUSE or DONE.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned NRO_DIGITOS = 4,
    parameter int unsigned SEC_DIV     = 50_000_000,
    parameter int unsigned SCAN_DIV    = 50_000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_stop,
    input  logic                             clear,
    input  logic                             load,
    input  BCDnumber_t [NRO_DIGITOS-1:0]     preset,
    output BCDnumber_t [NRO_DIGITOS-1:0]     num,
    output logic                             scan_tick,
    output timer_state_t                     state,
    output logic                             done
);

    if (NRO_DIGITOS != 4) begin : g_bad_digits
        $error("timer_ctrl: NRO_DIGITOS must be 4 (mm:ss)");
    end

    timer_state_t                 state_q, state_d;
    BCDnumber_t [NRO_DIGITOS-1:0] count_q, count_d;
    BCDnumber_t [NRO_DIGITOS-1:0] loaded, dec;
    logic                         sec_tick, sec_clr;

    tick_gen #(.DIV(SEC_DIV)) u_sec_tick (
        .clk   (clk),
        .rst   (rst | sec_clr),
        .en    (state_q == RUN),
        .pulse (sec_tick)
    );

    tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .pulse (scan_tick)
    );

    // State and count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Clamped preset and one-second BCD decrement with ripple borrow.
    always_comb begin
        for (int i = 0; i < NRO_DIGITOS; i++) begin
            loaded[i] = clamp_digit(preset[i], (i == 1) ? SEC_TENS_MAX : DIGIT_MAX);
        end
        dec = count_q;
        if (count_q[0] != '0) begin
            dec[0] = count_q[0] - 4'd1;
        end else begin
            dec[0] = DIGIT_MAX;
            if (count_q[1] != '0) begin
                dec[1] = count_q[1] - 4'd1;
            end else begin
                dec[1] = SEC_TENS_MAX;
                if (count_q[2] != '0) begin
                    dec[2] = count_q[2] - 4'd1;
                end else begin
                    dec[2] = DIGIT_MAX;
                    dec[3] = count_q[3] - 4'd1;
                end
            end
        end
    end

    // Next state; event priority clear > load > start_stop > sec tick.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sec_clr = 1'b0;
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            sec_clr = 1'b1;
        end else if (load && (state_q != RUN)) begin
            state_d = IDLE;
            count_d = loaded;
        end else if (start_stop) begin
            unique case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_d = RUN;
                        sec_clr = 1'b1;
                    end
                end
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = state_q;
            endcase
        end else if (sec_tick && (count_q != '0)) begin
            count_d = dec;
            if (dec == '0) begin
                state_d = DONE;
            end
        end
    end

`ifdef TIMER_CTRL_BLINK_EN
    localparam logic [31:0] HALF_LAST = (SEC_DIV / 2 > 1) ? 32'(SEC_DIV / 2 - 1) : 32'd0;

    logic [31:0] blink_cnt_q;
    logic        blink_phase_q;

    // Restarts on every state change so each PAUSE/DONE entry shows digits first.
    always_ff @(posedge clk) begin
        if (rst || (state_d != state_q)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == HALF_LAST) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q   <= blink_cnt_q + 32'd1;
        end
    end
`endif

    // Outputs.
    always_comb begin
        num   = count_q;
        state = state_q;
        done  = (state_q == DONE);
`ifdef TIMER_CTRL_BLINK_EN
        if (((state_q == PAUSE) || (state_q == DONE)) && blink_phase_q) begin
            for (int i = 0; i < NRO_DIGITOS; i++) begin
                num[i] = BCD_BLANK;
            end
        end
`endif
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: self-checking bench for timer_ctrl (SEC_DIV=10, SCAN_DIV=4).
// A reference model tracks the count as whole seconds and the time base as
// elapsed cycles; every cycle the DUT is compared against it, plus fixed
// vector tables and hand-written multi-cycle sequences.
module tb_timer_ctrl;
    import timer_ctrl_pkg::*;

    localparam int unsigned SEC_DIV  = 10;
    localparam int unsigned SCAN_DIV = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_stop = 1'b0;
    logic         clear = 1'b0;
    logic         load = 1'b0;
    logic [15:0]  preset = '0;
    logic [15:0]  num;
    logic         scan_tick;
    logic         done;
    timer_state_t state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    timer_ctrl #(
        .NRO_DIGITOS (4),
        .SEC_DIV     (SEC_DIV),
        .SCAN_DIV    (SCAN_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .load       (load),
        .preset     (preset),
        .num        (num),
        .scan_tick  (scan_tick),
        .state      (state),
        .done       (done)
    );

    // Reference model state.
    timer_state_t m_state;
    int           m_secs;      // remaining time in seconds
    int           m_phase;     // cycles elapsed in the current second
    int           m_scan_k;    // edges since the last reset edge
    int           m_in_state;  // edges since the last state change

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", what, act, exp, $time);
        end
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int preset_secs(input logic [15:0] p);
        int d0, d1, d2, d3;
        d0 = min_int(int'(p[3:0]), 9);
        d1 = min_int(int'(p[7:4]), 5);
        d2 = min_int(int'(p[11:8]), 9);
        d3 = min_int(int'(p[15:12]), 9);
        return (d3 * 10 + d2) * 60 + d1 * 10 + d0;
    endfunction

    function automatic logic [15:0] to_bcd(input int secs);
        int mm, ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_reset();
        m_state    = IDLE;
        m_secs     = 0;
        m_phase    = 0;
        m_scan_k   = 0;
        m_in_state = 0;
    endtask

    // Advance the model by one edge using the inputs sampled at that edge.
    task automatic model_edge();
        timer_state_t prev;
        bit           tick;
        prev = m_state;
        tick = (m_state == RUN) && (m_phase == int'(SEC_DIV) - 1);
        if (rst) begin
            model_reset();
            return;
        end
        m_scan_k++;
        if (m_state == RUN) m_phase = (m_phase + 1) % int'(SEC_DIV);
        if (clear) begin
            m_state = IDLE;
            m_secs  = 0;
            m_phase = 0;
        end else if (load && (m_state != RUN)) begin
            m_state = IDLE;
            m_secs  = preset_secs(preset);
        end else if (start_stop) begin
            if (m_state == IDLE && m_secs != 0) begin
                m_state = RUN;
                m_phase = 0;
            end else if (m_state == RUN) begin
                m_state = PAUSE;
            end else if (m_state == PAUSE) begin
                m_state = RUN;
            end
        end else if (tick && m_secs > 0) begin
            m_secs--;
            if (m_secs == 0) m_state = DONE;
        end
        m_in_state = (m_state != prev) ? 0 : m_in_state + 1;
    endtask

    task automatic check_model();
        logic [15:0] exp_num;
        exp_num = to_bcd(m_secs);
`ifdef TIMER_CTRL_BLINK_EN
        if ((m_state == PAUSE || m_state == DONE) &&
            (((m_in_state / int'(SEC_DIV / 2)) % 2) == 1)) exp_num = 16'hFFFF;
`endif
        check("model_num", 32'(num), 32'(exp_num));
        check("model_state", 32'(state), 32'(m_state));
        check("model_done", 32'(done), 32'(m_state == DONE));
        check("model_scan", 32'(scan_tick), 32'(((m_scan_k + 1) % int'(SCAN_DIV)) == 0));
    endtask

    task automatic step(input logic r, input logic c, input logic l, input logic s,
                        input logic [15:0] p);
        rst = r; clear = c; load = l; start_stop = s; preset = p;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
        rst = 1'b0; clear = 1'b0; load = 1'b0; start_stop = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, preset);
    endtask

    typedef struct {
        logic         r, c, l, s;
        logic [15:0]  p;
        timer_state_t st;
        logic [15:0]  n;
    } vec_t;

    vec_t tbl[16];

    initial begin
        model_reset();
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, IDLE,  16'h0000};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0102, IDLE,  16'h0102};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h137C, IDLE,  16'h1359};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, IDLE,  16'h9959};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, IDLE,  16'h0000};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, IDLE,  16'h0000};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, IDLE,  16'h0010};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, RUN,   16'h0010};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, PAUSE, 16'h0010};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, IDLE,  16'h0003};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, RUN,   16'h0003};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0500, RUN,   16'h0003};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0500, IDLE,  16'h0000};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, IDLE,  16'h0001};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, RUN,   16'h0001};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, IDLE,  16'h0000};

        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        check("reset_scan", 32'(scan_tick), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        // Single-cycle vector table.
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].c, tbl[i].l, tbl[i].s, tbl[i].p);
            check($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
            check($sformatf("tbl%0d_num", i), 32'(num), 32'(tbl[i].n));
        end

        // Full countdown 01:02 -> 00:00.
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0102);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0102);
        check("run_state", 32'(state), 32'(RUN));
        for (int i = 1; i <= 620; i++) begin
            idle(1);
            if (i == 9)   check("cd_9",   32'(num), 32'h0102);
            if (i == 10)  check("cd_10",  32'(num), 32'h0101);
            if (i == 30)  check("cd_30",  32'(num), 32'h0059);
            if (i == 619) check("cd_619", 32'(num), 32'h0001);
            if (i == 619) check("cd_619_state", 32'(state), 32'(RUN));
        end
        check("cd_done_state", 32'(state), 32'(DONE));
        check("cd_done", 32'(done), 32'd1);
`ifndef TIMER_CTRL_BLINK_EN
        check("cd_done_num", 32'(num), 32'h0000);
        idle(25);
        check("cd_nowrap", 32'(num), 32'h0000);
`else
        check("blink_vis0", 32'(num), 32'h0000);
        for (int k = 1; k < 10; k++) begin
            idle(1);
            check($sformatf("blink_k%0d", k), 32'(num), (k < 5) ? 32'h0000 : 32'hFFFF);
        end
        idle(15);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        check("done_ss_ignored", 32'(state), 32'(DONE));

        // Pause/resume keeps the partial second.
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0010);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0010);
        idle(4);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0010);
        check("pause_state", 32'(state), 32'(PAUSE));
        idle(50);
        check("pause_state_held", 32'(state), 32'(PAUSE));
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0010);
        idle(4);
        check("resume_4", 32'(num), 32'h0010);
        idle(1);
        check("resume_5", 32'(num), 32'h0009);

        // rst mid-RUN, then scan tick pattern across states.
        idle(3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        check("rst_mid_state", 32'(state), 32'(IDLE));
        check("rst_mid_num", 32'(num), 32'h0000);
        check("rst_mid_scan", 32'(scan_tick), 32'd0);
        for (int k = 1; k <= 24; k++) begin
            if (k == 2) step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0002);
            else if (k == 3) step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0002);
            else idle(1);
            check($sformatf("scan_k%0d", k), 32'(scan_tick), 32'((k % 4) == 3));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 599) == 0),
                 ($urandom_range(0, 119) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 14) == 0),
                 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
